// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with HI/LO registers: one shift-add or
// restoring-divide step per clock, start/busy/done handshake, MTHI/MTLO and flush.
`default_nettype none

module mdu_iterative #(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [data_width-1:0] in_s1,
    input  logic [data_width-1:0] in_s2,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [data_width-1:0] hi,
    output logic [data_width-1:0] lo
);

    localparam int CW = $clog2(data_width);
    localparam int DW = data_width;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*DW-1:0]   acc_q, acc_d;
    logic [DW-1:0]     opb_q, opb_d;
    logic [DW-1:0]     s1_raw_q, s1_raw_d;
    logic              is_div_q, is_div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;
    logic [DW-1:0]     hi_q, hi_d;
    logic [DW-1:0]     lo_q, lo_d;

    logic [DW:0]       mul_sum;
    logic [2*DW-1:0]   mul_next;
    logic [DW:0]       rem_sh;
    logic [DW:0]       rem_diff;
    logic [2*DW-1:0]   div_next;
    logic [2*DW-1:0]   prod_neg;
    logic [DW-1:0]     abs_s1;
    logic [DW-1:0]     abs_s2;
    logic              sign_op;

    // Datapath: the accumulator holds {partial product, multiplier} for
    // multiply and {partial remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*DW-1:DW]}
                 + (acc_q[0] ? {1'b0, opb_q} : {(DW+1){1'b0}});
        mul_next = {mul_sum, acc_q[DW-1:1]};
        rem_sh   = {acc_q[2*DW-1:DW], acc_q[DW-1]};
        rem_diff = rem_sh - {1'b0, opb_q};
        div_next = rem_diff[DW] ? {rem_sh[DW-1:0],   acc_q[DW-2:0], 1'b0}
                                : {rem_diff[DW-1:0], acc_q[DW-2:0], 1'b1};
        prod_neg = {(2*DW){1'b0}} - acc_q;
        sign_op  = (op == OP_MULT) || (op == OP_DIV);
        abs_s1   = (sign_op && in_s1[DW-1]) ? ({DW{1'b0}} - in_s1) : in_s1;
        abs_s2   = (sign_op && in_s2[DW-1]) ? ({DW{1'b0}} - in_s2) : in_s2;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        s1_raw_d  = s1_raw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d  = op[1];
                            neg_res_d = sign_op && (in_s1[DW-1] ^ in_s2[DW-1]);
                            neg_rem_d = sign_op && in_s1[DW-1];
                            s1_raw_d  = in_s1;
                            count_d   = {CW{1'b0}};
                            busy_d    = 1'b1;
                            state_d   = CALC;
                            if (op[1]) begin
                                acc_d = {{DW{1'b0}}, abs_s1};
                                opb_d = abs_s2;
                            end else begin
                                acc_d = {{DW{1'b0}}, abs_s2};
                                opb_d = abs_s1;
                            end
                        end
                        OP_MTHI: begin
                            hi_d   = in_s1;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = in_s1;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (flush) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    acc_d   = is_div_q ? div_next : mul_next;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(DW - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q && (opb_q == {DW{1'b0}})) begin
                        // Divide by zero reports the raw dividend, not its magnitude.
                        hi_d  = s1_raw_q;
                        lo_d  = {DW{1'b1}};
                        dbz_d = 1'b1;
                    end else if (is_div_q) begin
                        lo_d = neg_res_q ? ({DW{1'b0}} - acc_q[DW-1:0]) : acc_q[DW-1:0];
                        hi_d = neg_rem_q ? ({DW{1'b0}} - acc_q[2*DW-1:DW])
                                         : acc_q[2*DW-1:DW];
                    end else begin
                        {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= {CW{1'b0}};
            acc_q     <= {(2*DW){1'b0}};
            opb_q     <= {DW{1'b0}};
            s1_raw_q  <= {DW{1'b0}};
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= {DW{1'b0}};
            lo_q      <= {DW{1'b0}};
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            s1_raw_q  <= s1_raw_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative (data_width = 32).
`default_nettype none

module tb_mdu_iterative;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in_s1;
    logic [31:0] in_s2;
    logic        flush;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_err;
    int lat;
    int busy_cnt;
    int done_cnt;
    logic both;

    mdu_iterative #(.data_width(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .in_s1       (in_s1),
        .in_s2       (in_s2),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request at a falling edge and waits (bounded) for done.
    // lat counts falling edges from the drive to the first one seeing done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        in_s1 = a;
        in_s2 = b;
        lat = 0;
        busy_cnt = 0;
        both = 1'b0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) busy_cnt++;
            if (busy && done) both = 1'b1;
        end while (!done && lat < 100);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        in_s1 = 32'd0;
        in_s2 = 32'd0;
        flush = 1'b0;

        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MULT -3 * 7 = -21
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7);
        chk("mult_lat", 64'(lat), 64'd34);
        chk("mult_busy_cycles", 64'(busy_cnt), 64'd33);
        chk("mult_busy_done_overlap", 64'(both), 64'd0);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        @(negedge clk);
        chk("mult_done_pulse", 64'(done), 64'd0);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0001);

        run_op(3'd2, 32'hFFFF_FFF8, 32'd3);
        chk("div_lat", 64'(lat), 64'd34);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFE);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFE);

        run_op(3'd3, 32'hFFFF_FFF8, 32'd3);
        chk("divu_lo", 64'(lo), 64'h5555_5552);
        chk("divu_hi", 64'(hi), 64'h0000_0002);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_min_lo", 64'(lo), 64'h8000_0000);
        chk("div_min_hi", 64'(hi), 64'h0000_0000);
        chk("div_min_dbz", 64'(div_by_zero), 64'd0);

        run_op(3'd3, 32'd5, 32'd0);
        chk("dbz_lat", 64'(lat), 64'd34);
        chk("dbz_flag", 64'(div_by_zero), 64'd1);
        chk("dbz_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("dbz_hi", 64'(hi), 64'h0000_0005);

        run_op(3'd0, 32'd2, 32'd2);
        chk("mult2_dbz", 64'(div_by_zero), 64'd0);
        chk("mult2_lo", 64'(lo), 64'h0000_0004);
        chk("mult2_hi", 64'(hi), 64'h0000_0000);

        // Flush mid-multiply with a second start attempted while busy.
        @(negedge clk);
        start = 1'b1; op = 3'd0; in_s1 = 32'd9; in_s2 = 32'd9;
        done_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
            start = (i == 5);
            op    = (i == 5) ? 3'd4 : 3'd0;
            in_s1 = (i == 5) ? 32'hDEAD_BEEF : 32'd9;
            flush = (i == 11);
        end
        chk("flush_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        chk("flush_no_done", 64'(done_cnt), 64'd0);
        chk("flush_hi_kept", 64'(hi), 64'h0000_0000);
        chk("flush_lo_kept", 64'(lo), 64'h0000_0004);

        run_op(3'd5, 32'h0000_1234, 32'd0);
        chk("mtlo_lat", 64'(lat), 64'd1);
        chk("mtlo_lo", 64'(lo), 64'h0000_1234);
        chk("mtlo_busy", 64'(busy_cnt), 64'd0);
        @(negedge clk);
        chk("mtlo_done_pulse", 64'(done), 64'd0);

        run_op(3'd4, 32'hABCD_0001, 32'd0);
        chk("mthi_hi", 64'(hi), 64'hABCD_0001);

        // Reserved op and flush-blocked MTHI must leave everything untouched.
        @(negedge clk);
        start = 1'b1; op = 3'd6; in_s1 = 32'h1111_1111;
        @(negedge clk);
        start = 1'b1; op = 3'd4; flush = 1'b1;
        done_cnt = (done || busy) ? 1 : 0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        if (done || busy) done_cnt++;
        @(negedge clk);
        if (done || busy) done_cnt++;
        chk("ignored_no_done", 64'(done_cnt), 64'd0);
        chk("ignored_hi", 64'(hi), 64'hABCD_0001);
        chk("ignored_lo", 64'(lo), 64'h0000_1234);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; op = 3'd2; in_s1 = 32'd100; in_s2 = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd2, 32'hFFFF_FF9C, 32'd7);
        chk("div_after_rst_lat", 64'(lat), 64'd34);
        chk("div_after_rst_lo", 64'(lo), 64'hFFFF_FFF2);
        chk("div_after_rst_hi", 64'(hi), 64'hFFFF_FFFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It takes over MULT/MULTU/DIV/DIVU from the single-cycle ALU.
- Processes one bit per clock using a shift-add multiplier and a restoring divider, with a start/busy/done handshake toward the pipeline control.
- Also supports MTHI/MTLO writes and a flush for exception squashing.
- Width is parametrised.

Parameters:
- data_width, 32, operand width and width of HI and LO (must be >= 4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved.
- in_s1  input  data_width  multiplicand/dividend; MTHI/MTLO source.
- in_s2  input  data_width  multiplier/divisor.
- flush  input  1  abort the current operation.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; hi/lo updated on this cycle.
- div_by_zero  output  1  pulses with done when a DIV/DIVU had in_s2==0.
- hi  output  data_width  HI register.
- lo  output  data_width  LO register.

Behaviour:
Reset:
- rst_n low forces state IDLE immediately.
- busy=0, done=0, div_by_zero=0, hi=0, lo=0, iteration counter=0.
- Reset mid-operation discards all partial results.

States: IDLE, CALC, FIX.
- IDLE, start=1, op 0-3: latch operands and op, then go to CALC with count=0. busy rises at the same edge.
  - Signed ops latch absolute values and record the result signs: product sign = s1^s2, quotient sign = s1^s2, remainder sign = s1.
- IDLE, start=1, op 4/5: write in_s1 to hi (MTHI) or lo (MTLO) at that edge. Stay in IDLE. done pulses the following cycle; busy stays 0.
- IDLE, start=1, op 6/7: ignored. No state change, no done.
- CALC: one iteration per edge; count increments.
  - Multiply: 2*data_width-bit accumulator; add multiplicand when the current multiplier LSB is 1, then shift right.
  - Divide: shift remainder left, subtract divisor, restore if negative, shift the quotient bit in.
  - After data_width CALC edges (count==data_width-1 at the edge), go to FIX.
- FIX, one edge:
  - Apply two's-complement sign correction.
  - Write hi = upper half (product) or remainder; lo = lower half (product) or quotient.
  - Assert done for exactly one cycle, clear busy, return to IDLE.

Latency:
- Edge sampling start = E0. done is high in the cycle after edge E0+data_width+1, i.e. 34 edges after E0 for data_width=32.
- hi/lo are stable and valid from that cycle until the next update.

Handshake:
- start while busy=1 is ignored; no queueing.
- start may be held high; a new operation is accepted on the edge where done is high, because state is already IDLE.
- done and busy are never both 1.

Arithmetic:
- MULT/MULTU: full 2*data_width-bit product.
- DIV: quotient truncates toward zero; remainder takes the dividend's sign.
- Most-negative / -1: lo = most-negative value, hi = 0, no flag.
- Divide by zero: lo = all ones, hi = in_s1 (raw latched value, no sign fix), div_by_zero=1 with done. Full latency is kept.

Flush:
- flush=1 in CALC or FIX returns to IDLE at that edge. busy clears, no done, hi/lo unchanged.
- flush has priority over FIX completion.
- flush in IDLE blocks a simultaneous start, including MTHI/MTLO.

Test Plan:
- MULT in_s1=-3, in_s2=7 -> done exactly 34 cycles after start, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
- MULTU in_s1=0xFFFFFFFF, in_s2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -8/3 -> lo=-2, hi=-2; DIVU 0xFFFFFFF8/3 -> lo=0x55555552, hi=2; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero pulses with done; a following MULT 2*2 leaves div_by_zero=0, lo=4.
- Start MULT, pulse flush at CALC cycle 10, second start asserted while busy -> no done, hi/lo keep prior values, second start ignored; MTLO 0x1234 afterwards -> lo=0x1234 at next edge, done 1 cycle later.
- Assert rst_n=0 asynchronously mid-DIV -> busy/done/hi/lo read 0 before the next clock edge; a fresh DIV after release completes correctly.
